// File: rtl/vga_axis_timer_pkg.sv
// -----------------------------------------------------------------------------
// vga_axis_timer_pkg
// Shared definitions for the VGA axis timing generator:
//   - phase_t     : the four phases one axis walks through each line/frame
//   - VGA_H_* / VGA_V_* : 800x600@60 horizontal and vertical timing, in pixels
//                   and lines, for users that build a raster from two axes
//   - clamp_geom  : maps a requested length onto the legal range 1..max
// -----------------------------------------------------------------------------
package vga_axis_timer_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    // 800x600@60 (40 MHz pixel clock) reference timing.
    localparam int VGA_H_ACTIVE = 800;
    localparam int VGA_H_FRONT  = 40;
    localparam int VGA_H_SYNC   = 128;
    localparam int VGA_H_BACK   = 88;
    localparam int VGA_V_ACTIVE = 600;
    localparam int VGA_V_FRONT  = 1;
    localparam int VGA_V_SYNC   = 4;
    localparam int VGA_V_BACK   = 23;

    // A zero length would make a phase last forever, so it becomes 1;
    // anything above the configured maximum saturates at the maximum.
    function automatic int unsigned clamp_geom(input int unsigned v,
                                               input int unsigned max_v);
        if (v == 32'd0) begin
            return 32'd1;
        end else if (v > max_v) begin
            return max_v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/vga_axis_shadow.sv
// -----------------------------------------------------------------------------
// vga_axis_shadow
// Holds the live geometry used by the axis counter plus a pending copy.
// A load clamps the requested values into the pending copy; the pending copy
// becomes live only when i_commit (the axis carry) fires, i.e. exactly at the
// line/frame wrap, so the live geometry never changes mid-frame.
// Ports:
//   clk, reset_low          clock, asynchronous active-low reset
//   i_cfg_load              capture i_cfg_* (clamped) into the pending copy
//   i_cfg_blocks/pixels/front/sync/back   requested geometry
//   i_commit                wrap strobe; promotes pending to live if loaded
//   o_live_*                geometry currently in use
//   o_cfg_pending           pending copy loaded but not yet committed
// -----------------------------------------------------------------------------
module vga_axis_shadow
    import vga_axis_timer_pkg::*;
#(
    parameter int BLOCKS_MAX = 80,
    parameter int PIXELS_MAX = 10,
    parameter int PORCH_MAX  = 1023,
    parameter int DEF_BLOCKS = 80,
    parameter int DEF_PIXELS = 10,
    parameter int DEF_FRONT  = 210,
    parameter int DEF_SYNC   = 1,
    parameter int DEF_BACK   = 45,
    localparam int BCW = $clog2(BLOCKS_MAX) + 1,
    localparam int PCW = $clog2(PIXELS_MAX) + 1,
    localparam int QW  = $clog2(PORCH_MAX + 1)
)(
    input  logic           clk,
    input  logic           reset_low,
    input  logic           i_cfg_load,
    input  logic [BCW-1:0] i_cfg_blocks,
    input  logic [PCW-1:0] i_cfg_pixels,
    input  logic [QW-1:0]  i_cfg_front,
    input  logic [QW-1:0]  i_cfg_sync,
    input  logic [QW-1:0]  i_cfg_back,
    input  logic           i_commit,
    output logic [BCW-1:0] o_live_blocks,
    output logic [PCW-1:0] o_live_pixels,
    output logic [QW-1:0]  o_live_front,
    output logic [QW-1:0]  o_live_sync,
    output logic [QW-1:0]  o_live_back,
    output logic           o_cfg_pending
);

    logic [BCW-1:0] w_blocks;
    logic [PCW-1:0] w_pixels;
    logic [QW-1:0]  w_front;
    logic [QW-1:0]  w_sync;
    logic [QW-1:0]  w_back;

    logic [BCW-1:0] r_pend_blocks;
    logic [PCW-1:0] r_pend_pixels;
    logic [QW-1:0]  r_pend_front;
    logic [QW-1:0]  r_pend_sync;
    logic [QW-1:0]  r_pend_back;
    logic           r_pending;

    logic [BCW-1:0] r_live_blocks;
    logic [PCW-1:0] r_live_pixels;
    logic [QW-1:0]  r_live_front;
    logic [QW-1:0]  r_live_sync;
    logic [QW-1:0]  r_live_back;

    // Clamp the requested geometry before it is captured.
    always_comb begin
        w_blocks = BCW'(clamp_geom(32'(i_cfg_blocks), BLOCKS_MAX));
        w_pixels = PCW'(clamp_geom(32'(i_cfg_pixels), PIXELS_MAX));
        w_front  = QW'(clamp_geom(32'(i_cfg_front), PORCH_MAX));
        w_sync   = QW'(clamp_geom(32'(i_cfg_sync), PORCH_MAX));
        w_back   = QW'(clamp_geom(32'(i_cfg_back), PORCH_MAX));
    end

    // Pending and live registers. Commit reads the old pending copy, so a
    // load on the same edge is captured for the following wrap instead.
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            r_pend_blocks <= BCW'(DEF_BLOCKS);
            r_pend_pixels <= PCW'(DEF_PIXELS);
            r_pend_front  <= QW'(DEF_FRONT);
            r_pend_sync   <= QW'(DEF_SYNC);
            r_pend_back   <= QW'(DEF_BACK);
            r_pending     <= 1'b0;
            r_live_blocks <= BCW'(DEF_BLOCKS);
            r_live_pixels <= PCW'(DEF_PIXELS);
            r_live_front  <= QW'(DEF_FRONT);
            r_live_sync   <= QW'(DEF_SYNC);
            r_live_back   <= QW'(DEF_BACK);
        end else begin
            if (i_commit && r_pending) begin
                r_live_blocks <= r_pend_blocks;
                r_live_pixels <= r_pend_pixels;
                r_live_front  <= r_pend_front;
                r_live_sync   <= r_pend_sync;
                r_live_back   <= r_pend_back;
            end
            if (i_cfg_load) begin
                r_pend_blocks <= w_blocks;
                r_pend_pixels <= w_pixels;
                r_pend_front  <= w_front;
                r_pend_sync   <= w_sync;
                r_pend_back   <= w_back;
                r_pending     <= 1'b1;
            end else if (i_commit) begin
                r_pending     <= 1'b0;
            end
        end
    end

    assign o_live_blocks = r_live_blocks;
    assign o_live_pixels = r_live_pixels;
    assign o_live_front  = r_live_front;
    assign o_live_sync   = r_live_sync;
    assign o_live_back   = r_live_back;
    assign o_cfg_pending = r_pending;

endmodule

// File: rtl/vga_axis_timer.sv
// -----------------------------------------------------------------------------
// vga_axis_timer
// Timing generator for one VGA axis. Each increment advances one position
// through ACTIVE (blocks x pixels) -> FRONT -> SYNC -> BACK; carry marks the
// last BACK position so a second instance can count lines from it.
// Ports:
//   clk, reset_low        clock, asynchronous active-low reset
//   increment             advance one position (clock enable / previous carry)
//   cfg_load, cfg_*       request new geometry (applied at the next wrap)
//   cfg_pending           request captured, not yet applied
//   carry                 increment on the final BACK position (combinational)
//   active                registered, high throughout ACTIVE
//   start                 active at block 0 / pixel 0
//   sync                  sync pulse, polarity set by SYNC_ACTIVE_LOW
//   block, pixel          position inside the active span
// -----------------------------------------------------------------------------
module vga_axis_timer
    import vga_axis_timer_pkg::*;
#(
    parameter int BLOCKS_MAX      = 80,
    parameter int PIXELS_MAX      = 10,
    parameter int PORCH_MAX       = 1023,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int DEF_BLOCKS      = 80,
    parameter int DEF_PIXELS      = 10,
    parameter int DEF_FRONT       = 210,
    parameter int DEF_SYNC        = 1,
    parameter int DEF_BACK        = 45,
    localparam int BW = $clog2(BLOCKS_MAX),
    localparam int PW = $clog2(PIXELS_MAX),
    localparam int QW = $clog2(PORCH_MAX + 1)
)(
    input  logic          clk,
    input  logic          reset_low,
    input  logic          increment,
    input  logic          cfg_load,
    input  logic [BW:0]   cfg_blocks,
    input  logic [PW:0]   cfg_pixels,
    input  logic [QW-1:0] cfg_front,
    input  logic [QW-1:0] cfg_sync,
    input  logic [QW-1:0] cfg_back,
    output logic          cfg_pending,
    output logic          carry,
    output logic          active,
    output logic          start,
    output logic          sync,
    output logic [BW-1:0] block,
    output logic [PW-1:0] pixel
);

    localparam logic [BW:0]   BCW_ONE = (BW + 1)'(1'b1);
    localparam logic [PW:0]   PCW_ONE = (PW + 1)'(1'b1);
    localparam logic [BW-1:0] BLK_ONE = BW'(1'b1);
    localparam logic [PW-1:0] PIX_ONE = PW'(1'b1);
    localparam logic [QW-1:0] Q_ONE   = QW'(1'b1);

    logic [BW:0]   w_live_blocks;
    logic [PW:0]   w_live_pixels;
    logic [QW-1:0] w_live_front;
    logic [QW-1:0] w_live_sync;
    logic [QW-1:0] w_live_back;
    logic [QW-1:0] w_len;
    logic          w_cnt_last;
    logic          w_pix_last;
    logic          w_blk_last;
    logic          w_carry;

    phase_t        r_phase;
    logic [QW-1:0] r_count;
    logic [BW-1:0] r_block;
    logic [PW-1:0] r_pixel;
    logic          r_active;

    vga_axis_shadow #(
        .BLOCKS_MAX (BLOCKS_MAX),
        .PIXELS_MAX (PIXELS_MAX),
        .PORCH_MAX  (PORCH_MAX),
        .DEF_BLOCKS (DEF_BLOCKS),
        .DEF_PIXELS (DEF_PIXELS),
        .DEF_FRONT  (DEF_FRONT),
        .DEF_SYNC   (DEF_SYNC),
        .DEF_BACK   (DEF_BACK)
    ) u_shadow (
        .clk           (clk),
        .reset_low     (reset_low),
        .i_cfg_load    (cfg_load),
        .i_cfg_blocks  (cfg_blocks),
        .i_cfg_pixels  (cfg_pixels),
        .i_cfg_front   (cfg_front),
        .i_cfg_sync    (cfg_sync),
        .i_cfg_back    (cfg_back),
        .i_commit      (w_carry),
        .o_live_blocks (w_live_blocks),
        .o_live_pixels (w_live_pixels),
        .o_live_front  (w_live_front),
        .o_live_sync   (w_live_sync),
        .o_live_back   (w_live_back),
        .o_cfg_pending (cfg_pending)
    );

    // Length of the porch/sync phase currently being counted.
    always_comb begin
        case (r_phase)
            PH_FRONT: w_len = w_live_front;
            PH_SYNC:  w_len = w_live_sync;
            PH_BACK:  w_len = w_live_back;
            default:  w_len = w_live_back;
        endcase
    end

    assign w_cnt_last = (r_count == (w_len - Q_ONE));
    assign w_pix_last = ({1'b0, r_pixel} == (w_live_pixels - PCW_ONE));
    assign w_blk_last = ({1'b0, r_block} == (w_live_blocks - BCW_ONE));
    assign w_carry    = increment & (r_phase == PH_BACK) &
                        (r_count == (w_live_back - Q_ONE));

    // Position counter FSM; increment low freezes everything.
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            r_phase  <= PH_FRONT;
            r_count  <= '0;
            r_block  <= '0;
            r_pixel  <= '0;
            r_active <= 1'b0;
        end else if (increment) begin
            case (r_phase)
                PH_ACTIVE: begin
                    if (w_pix_last) begin
                        r_pixel <= '0;
                        if (w_blk_last) begin
                            r_phase  <= PH_FRONT;
                            r_count  <= '0;
                            r_block  <= '0;
                            r_active <= 1'b0;
                        end else begin
                            r_block <= r_block + BLK_ONE;
                        end
                    end else begin
                        r_pixel <= r_pixel + PIX_ONE;
                    end
                end
                PH_FRONT: begin
                    if (w_cnt_last) begin
                        r_phase <= PH_SYNC;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + Q_ONE;
                    end
                end
                PH_SYNC: begin
                    if (w_cnt_last) begin
                        r_phase <= PH_BACK;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + Q_ONE;
                    end
                end
                default: begin
                    if (w_cnt_last) begin
                        r_phase  <= PH_ACTIVE;
                        r_count  <= '0;
                        r_block  <= '0;
                        r_pixel  <= '0;
                        r_active <= 1'b1;
                    end else begin
                        r_count <= r_count + Q_ONE;
                    end
                end
            endcase
        end
    end

    assign carry  = w_carry;
    assign active = r_active;
    assign block  = r_block;
    assign pixel  = r_pixel;
    assign start  = r_active & (r_block == {BW{1'b0}}) & (r_pixel == {PW{1'b0}});
    assign sync   = (r_phase == PH_SYNC) ^ SYNC_ACTIVE_LOW;

endmodule
